mem_port_arbiter: RTL and testbench

Shares one single-ported, 1-cycle-read-latency backing SRAM between the CPU instruction-fetch requester and the data-access requester. Sits between `rv32i_cpu` and a single-port `simple_memory` variant, letting the core run against realistic one-port memory. Data accesses have priority; a starvation counter bounds fetch delay. Read data is routed back to the granted requester one cycle after grant.

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/arb_starve_ctr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package rv32i_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_BE_W-1:0]   we;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic is_read(input logic [MEM_BE_W-1:0] we);
    return we == '0;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive cycles a fetch request waits; forces fetch through at STARVE_MAX.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_o
);

  localparam logic [7:0] MAX_C = 8'(STARVE_MAX);

  logic [7:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!req_i || gnt_i) begin
      starve_d = '0;
    end else if (starve_q != MAX_C) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_o = (starve_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port, 1-cycle-latency SRAM between fetch and data requesters.
// Data wins by default; a starvation counter bounds how long fetch can be held off.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [15:0]       conflict_cnt
);

  logic        starve_force;
  owner_e      own_q, own_d;
  logic [15:0] conflict_q, conflict_d;
  mem_req_t    win_req;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (i_req),
    .gnt_i  (i_gnt),
    .force_o(starve_force)
  );

  // Grants stay low while reset is held so nothing reaches the SRAM.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    win_req = '0;
    own_d   = OWN_NONE;
    if (!rst) begin
      if (i_req && (starve_force || !d_req)) begin
        i_gnt        = 1'b1;
        win_req.addr = MEM_ADDR_W'(i_addr);
        own_d        = OWN_I;
      end else if (d_req) begin
        d_gnt         = 1'b1;
        win_req.addr  = MEM_ADDR_W'(d_addr);
        win_req.we    = d_we;
        win_req.wdata = MEM_DATA_W'(d_wdata);
        if (is_read(d_we)) begin
          own_d = OWN_D;
        end
      end
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (i_req && d_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q      <= OWN_NONE;
      conflict_q <= '0;
    end else begin
      own_q      <= own_d;
      conflict_q <= conflict_d;
    end
  end

  assign m_en    = i_gnt | d_gnt;
  assign m_we    = win_req.we;
  assign m_addr  = ADDR_W'(win_req.addr);
  assign m_wdata = DATA_W'(win_req.wdata);

  assign i_rvalid     = (own_q == OWN_I);
  assign d_rvalid     = (own_q == OWN_D);
  assign i_rdata      = i_rvalid ? m_rdata : '0;
  assign d_rdata      = d_rvalid ? m_rdata : '0;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected read data,
// a monitor pops and compares whenever a read-valid appears.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic [15:0] conflict_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  logic [31:0] mem [0:1023];
  logic [31:0] wmerge;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Single-port SRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we == 4'b0000) begin
        m_rdata <= mem[m_addr[11:2]];
      end else begin
        wmerge = mem[m_addr[11:2]];
        for (int b = 0; b < 4; b++) begin
          if (m_we[b]) wmerge[8*b +: 8] = m_wdata[8*b +: 8];
        end
        mem[m_addr[11:2]] <= wmerge;
      end
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0050_0093;
      32'h200: return 32'hDEAD_BEEF;
      32'h300: return 32'hAAAA_AAAA;
      default: return 32'hC0DE_0000 | {22'd0, a[11:2]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    next_cycle();
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 4'b0000;
    @(negedge clk);
  endtask

  // Both requesters contend for n cycles with reads; data address steps by da_step.
  task automatic contend(input int n, input bit hold_i, input logic [31:0] ia,
                         input logic [31:0] da_base, input logic [31:0] da_step);
    bit          i_on = 1'b1;
    bit          exp_i;
    logic [31:0] da;
    for (int c = 1; c <= n; c++) begin
      next_cycle();
      da     = da_base + da_step * c;
      i_req  = i_on;
      i_addr = ia;
      d_req  = 1'b1;
      d_we   = 4'b0000;
      d_addr = da;
      @(negedge clk);
      exp_i = hold_i ? ((c % (STARVE_MAX + 1)) == 0) : (c == STARVE_MAX + 1);
      check("contend_i_gnt", i_gnt, exp_i);
      check("contend_d_gnt", d_gnt, !exp_i);
      if (exp_i) iq.push_back(exp_word(ia));
      else       dq.push_back(exp_word(da));
      if (exp_i && !hold_i) i_on = 1'b0;
    end
  endtask

  // Monitor: every valid must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (i_rvalid) begin
        if (iq.size() == 0) check("i_rvalid_unexpected", 32'd1, 32'd0);
        else                check("i_rdata", i_rdata, iq.pop_front());
      end else begin
        check("i_rdata_idle", i_rdata, 32'd0);
      end
      if (d_rvalid) begin
        if (dq.size() == 0) check("d_rvalid_unexpected", 32'd1, 32'd0);
        else                check("d_rdata", d_rdata, dq.pop_front());
      end else begin
        check("d_rdata_idle", d_rdata, 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE_0000 | k;
    mem[32'h40] = 32'h0050_0093;
    mem[32'h80] = 32'hDEAD_BEEF;
    mem[32'hC0] = 32'hAAAA_AAAA;

    // Reset held with both requesting: no grants, nothing counted.
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1;
    d_we = 4'b0000; d_addr = 32'h200; d_wdata = '0;
    next_cycle();
    check("rst_i_gnt", i_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_m_en", m_en, 0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_conflict", conflict_cnt, 0);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Uncontested fetch.
    next_cycle();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    check("f_i_gnt", i_gnt, 1);
    check("f_d_gnt", d_gnt, 0);
    check("f_m_en", m_en, 1);
    check("f_m_addr", m_addr, 32'h100);
    check("f_m_we", m_we, 0);
    check("f_m_wdata", m_wdata, 0);
    iq.push_back(32'h0050_0093);
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    check("f_idle_m_en", m_en, 0);
    check("f_idle_m_addr", m_addr, 0);
    check("f_d_rvalid", d_rvalid, 0);

    // Contention: data first, fetch the following cycle.
    next_cycle();
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h200;
    @(negedge clk);
    check("c_d_gnt", d_gnt, 1);
    check("c_i_gnt", i_gnt, 0);
    check("c_m_addr", m_addr, 32'h200);
    dq.push_back(32'hDEAD_BEEF);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check("c2_i_gnt", i_gnt, 1);
    check("c2_m_addr", m_addr, 32'h104);
    check("c2_conflict", conflict_cnt, 1);
    iq.push_back(32'hC0DE_0041);
    idle();

    // Starvation bound: fetch forced through on cycle STARVE_MAX+1.
    contend(10, 1'b0, 32'h10C, 32'h200, 32'd4);
    idle();
    check("s_conflict", conflict_cnt, 6);

    // Partial write then readback of the merged word.
    next_cycle();
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h300; d_wdata = 32'h1234_5678;
    @(negedge clk);
    check("w_d_gnt", d_gnt, 1);
    check("w_m_we", m_we, 4'b0011);
    check("w_m_wdata", m_wdata, 32'h1234_5678);
    check("w_m_addr", m_addr, 32'h300);
    next_cycle();
    d_we = 4'b0000;
    @(negedge clk);
    check("w_d_rvalid_after_write", d_rvalid, 0);
    check("r_d_gnt", d_gnt, 1);
    dq.push_back(32'hAAAA_5678);
    idle();

    // Reset asserted mid-cycle with a response in flight and starve count nonzero.
    next_cycle();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    check("r0_i_gnt", i_gnt, 1);
    iq.push_back(32'h0050_0093);
    next_cycle();
    i_addr = 32'h104; d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h200;
    @(negedge clk);
    check("r1_d_gnt", d_gnt, 1);
    dq.push_back(32'hDEAD_BEEF);
    next_cycle();
    d_addr = 32'h204;
    @(negedge clk);
    check("r2_d_gnt", d_gnt, 1);
    check("r2_conflict", conflict_cnt, 7);
    #2;
    rst = 1'b1;
    #1;
    check("ra_i_gnt", i_gnt, 0);
    check("ra_d_gnt", d_gnt, 0);
    check("ra_m_en", m_en, 0);
    check("ra_d_rvalid", d_rvalid, 0);
    check("ra_d_rdata", d_rdata, 0);
    check("ra_i_rvalid", i_rvalid, 0);
    check("ra_conflict", conflict_cnt, 0);
    next_cycle();
    check("rb_d_rvalid", d_rvalid, 0);
    check("rb_conflict", conflict_cnt, 0);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    contend(10, 1'b0, 32'h110, 32'h220, 32'd4);
    idle();
    check("rs_conflict", conflict_cnt, 5);

    // Long contention: fetch every STARVE_MAX+1 cycles, counter saturates.
    contend(70000, 1'b1, 32'h100, 32'h200, 32'd0);
    idle();
    check("sat_conflict", conflict_cnt, 16'hFFFF);
    idle();
    idle();
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
